// File: rtl/bram_engine_sched.sv
// bram_engine_sched: time-multiplexes one shared BRAM port between three
// engines. A start request latches a job mask; selected engines are then
// released from reset one at a time (lowest index first), given the BRAM
// with their base address added, and put back into reset when they report
// done.
// Optional feature: define SCHED_TIMEOUT_EN to bound each engine's RUN time
// by TIMEOUT cycles and expose the sticky timeout_err output.
module bram_engine_sched #(
    parameter logic [11:0] BASE0   = 12'd0,
    parameter logic [11:0] BASE1   = 12'd512,
    parameter logic [11:0] BASE2   = 12'd1024,
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op_mask,
    output logic [2:0]   eng_rst,
    input  logic [2:0]   eng_done,
    input  logic [26:0]  eng_read_address,
    input  logic [26:0]  eng_write_address,
    input  logic [191:0] eng_write_data,
    input  logic [2:0]   eng_write_en,
    output logic [11:0]  bram_read_address,
    output logic [11:0]  bram_write_address,
    output logic [63:0]  bram_write_data,
    output logic         bram_write_en,
    output logic         busy,
    output logic [1:0]   cur_eng,
    output logic         done
`ifdef SCHED_TIMEOUT_EN
    ,
    output logic         timeout_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_RELEASE,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t      state, state_next;
    logic [2:0]  pending, pending_next;
    logic [1:0]  owner, owner_next;

    // Per-owner views of the engine buses.
    logic [11:0] owner_base;
    logic [8:0]  owner_rd_addr;
    logic [8:0]  owner_wr_addr;
    logic [63:0] owner_wr_data;
    logic        owner_wr_en;
    logic        owner_done;
    logic [2:0]  owner_onehot;

    logic        owns_bram;
    logic        start_accept;
    logic        run_timeout;

    assign owns_bram    = (state == S_RELEASE) || (state == S_RUN);
    assign start_accept = start && ((state == S_IDLE) || (state == S_FINISH));

`ifdef SCHED_TIMEOUT_EN
    logic [15:0] run_cnt;

    assign run_timeout = (state == S_RUN) && (run_cnt == TIMEOUT - 16'd1);

    // RUN-cycle counter, restarted each time an engine is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= 16'd0;
        end else if (state == S_RELEASE) begin
            run_cnt <= 16'd0;
        end else if (state == S_RUN) begin
            run_cnt <= run_cnt + 16'd1;
        end
    end

    // Sticky timeout flag; a real done in the same cycle wins over a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (start_accept) begin
            timeout_err <= 1'b0;
        end else if (run_timeout && !owner_done) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign run_timeout = 1'b0;
`endif

    // Route the owning engine's signals; owner only ever holds 0..2.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        owner_base    = BASE0;
        owner_rd_addr = eng_read_address[8:0];
        owner_wr_addr = eng_write_address[8:0];
        owner_wr_data = eng_write_data[63:0];
        owner_wr_en   = eng_write_en[0];
        owner_done    = eng_done[0];
        owner_onehot  = 3'b001;
        case (owner)
            2'd1: begin
                owner_base    = BASE1;
                owner_rd_addr = eng_read_address[17:9];
                owner_wr_addr = eng_write_address[17:9];
                owner_wr_data = eng_write_data[127:64];
                owner_wr_en   = eng_write_en[1];
                owner_done    = eng_done[1];
                owner_onehot  = 3'b010;
            end
            2'd2: begin
                owner_base    = BASE2;
                owner_rd_addr = eng_read_address[26:18];
                owner_wr_addr = eng_write_address[26:18];
                owner_wr_data = eng_write_data[191:128];
                owner_wr_en   = eng_write_en[2];
                owner_done    = eng_done[2];
                owner_onehot  = 3'b100;
            end
            default: ;
        endcase
    end

    // State, job mask and owner registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state   <= S_IDLE;
            pending <= 3'b000;
            owner   <= 2'd0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            owner   <= owner_next;
        end
    end

    // Next-state logic: serve pending engines lowest index first.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        owner_next   = owner;
        case (state)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    pending_next = op_mask;
                    state_next   = S_SEL;
                end
            end
            S_SEL: begin
                if (pending == 3'b000) begin
                    state_next = S_FINISH;
                end else begin
                    if (pending[0])      owner_next = 2'd0;
                    else if (pending[1]) owner_next = 2'd1;
                    else                 owner_next = 2'd2;
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: state_next = S_RUN;
            S_RUN: begin
                if (owner_done || run_timeout) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                pending_next = pending & ~owner_onehot;
                state_next   = S_SEL;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the BRAM path is purely combinational.
    always_comb begin
        eng_rst            = 3'b111;
        cur_eng            = 2'd3;
        bram_read_address  = 12'd0;
        bram_write_address = 12'd0;
        bram_write_data    = 64'd0;
        bram_write_en      = 1'b0;
        busy               = (state == S_SEL) || (state == S_RELEASE) ||
                             (state == S_RUN) || (state == S_DRAIN);
        done               = (state == S_FINISH);
        if (owns_bram) begin
            eng_rst           = ~owner_onehot;
            cur_eng           = owner;
            bram_read_address = owner_base + {3'b000, owner_rd_addr};
        end
        if (state == S_RUN) begin
            bram_write_address = owner_base + {3'b000, owner_wr_addr};
            bram_write_data    = owner_wr_data;
            bram_write_en      = owner_wr_en;
        end
    end

endmodule
